sprite_compositor: RTL
======================

// Module: sprite_compositor
// PURPOSE
//  Parametrised N-layer sprite compositor. Sits between the game-logic blocks and
//  the VGA controller. Per pixel it computes sprite hits and ROM addresses, fetches
//  sprite ROM data (external, 1-cycle sync read), applies the transparency key and
//  fixed priority, and outputs registered RGB.
//  Also owns the PLAY/FADE/OVER screen mode and per-frame sprite collision flags.
// PARAMETERS
//  NUM_SPR      8          number of sprite layers; index 0 = highest priority
//  ADDR_W       19         sprite ROM address width
//  KEY_COLOR    24'hFF0000 transparent colour in sprite ROM data
//  BG_COLOR     24'hB7FE7B playfield background colour
//  FADE_FRAMES  4          frames spent in FADE (1..8)
//  OVL_IDX      NUM_SPR-1  sprite layer drawn in OVER mode (winner banner)
// PORTS
//  Clk          in   1              pixel clock
//  Reset_n      in   1              asynchronous reset, active low
//  pix_valid    in   1              DrawX/DrawY valid (active video)
//  frame_start  in   1              1-cycle pulse at first pixel of frame
//  DrawX,DrawY  in   10 each        current pixel coordinates
//  spr_en       in   NUM_SPR        per-layer enable
//  spr_x,spr_y  in   NUM_SPR*10     top-left corner per layer
//  spr_wlog2    in   NUM_SPR*3      width = 1<<wlog2 (1..128 px)
//  spr_h        in   NUM_SPR*8      height in px (0 = layer never hits)
//  rom_addr     out  NUM_SPR*ADDR_W per-layer ROM address, registered
//  rom_data     in   NUM_SPR*24     per-layer ROM RGB, valid 1 cycle after rom_addr
//  game_over    in   1              pulse: enter FADE
//  restart      in   1              pulse: return to PLAY
//  out_valid    out  1              VGA_R/G/B correspond to a valid pixel
//  VGA_R,G,B    out  8 each         output colour
//  coll_mask    out  NUM_SPR        bit i: layer i opaquely overlapped another last frame
//  mode         out  2              0 PLAY, 1 FADE, 2 OVER
// BEHAVIOUR
//  Reset: all outputs 0, mode=PLAY, fade_step=0, rom_addr=0, coll_mask=0, pipe valid=0.
//  Pipeline, latency 2 cycles pixel-in to RGB-out; out_valid = pix_valid delayed 2.
//   S0 (reg): hit[i] = en & X in [x, x+(1<<wlog2)) & Y in [y, y+h); compare in 11 bits,
//     no wrap at 1023. rom_addr[i] = (X-x) + ((Y-y)<<wlog2), zero-extended; 0 if !hit.
//   S1 (reg): opaque[i] = hit_d[i] & rom_data[i]!=KEY_COLOR; lowest-index opaque wins;
//     none opaque -> BG_COLOR. Invalid pixel -> RGB 0.
//  Mode FSM (transitions take effect on next frame_start, never mid-frame):
//   PLAY: game_over seen -> pending; at frame_start -> FADE, fade_step=0.
//   FADE: each frame_start fade_step++; composed RGB >> fade_step per channel;
//     at fade_step==FADE_FRAMES-1 frame_start -> OVER.
//   OVER: background 0; only layer OVL_IDX drawn (key still honoured).
//   restart pending from any mode -> PLAY at next frame_start; restart beats game_over
//     if both pending. Pending flags cleared on transition.
//  Collision: accumulator acc[i] |= opaque[i] & (popcount(opaque)>=2) on valid pixels;
//   at frame_start coll_mask<=acc, acc<=0 (a pixel coincident with frame_start counts
//   toward the new frame). coll_mask stable for a full frame. Forced 0 outside PLAY.
//  Reset_n low mid-frame: pipeline flushed immediately; first frame_start after release
//   starts a clean frame.
// CONFIGURATION
//  SPRITE_COLLISION_EN defined: collision accumulator and coll_mask as above.
//  Not defined: no accumulator logic; coll_mask tied to 0.
// STRUCTURE
//  sprite_pkg: mode_e enum {PLAY,FADE,OVER}, rgb_t packed struct {r,g,b},
//   KEY/BG colour localparams, sprite_desc_t {x,y,wlog2,h,en}.
//  One sub-module: sprite_hit_unit (per-layer S0 hit + address), instantiated
//   NUM_SPR times in a generate loop.
// TESTING
//  1 layer 0 at (100,50), wlog2=5, h=32, ROM=addr pattern; pixel (105,52) ->
//    rom_addr=69, RGB = rom_data, out_valid 2 cycles later.
//  Layers 0,1 overlap opaque at (200,200) -> layer 0 colour; layer 0 returns KEY -> layer 1 colour.
//  Layer at x=1010, wlog2=5: DrawX=3 -> no hit (no wrap); h=0 -> never hits.
//  game_over mid-frame -> mode stays PLAY to frame_start, FADE for 4 frames with RGB
//    >>0,1,2,3, then OVER: background 0, only OVL_IDX visible.
//  With SPRITE_COLLISION_EN: layers 2,5 overlap opaquely in frame N -> coll_mask=0x24
//    after frame N+1 start, 0 after N+2 if separated; without macro coll_mask=0.
//  Reset_n asserted mid-line -> all outputs 0 same cycle; restart+game_over same
//    frame -> PLAY.

Source files
------------

// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the sprite compositor:
//   mode_e        screen mode (PLAY / FADE / OVER)
//   rgb_t         packed 24-bit colour {r,g,b}
//   sprite_desc_t per-layer placement descriptor {x,y,wlog2,h,en}
//   rgb_shr       per-channel right shift used by the fade effect
// -----------------------------------------------------------------------------
package sprite_pkg;

  typedef enum logic [1:0] {
    MODE_PLAY = 2'd0,
    MODE_FADE = 2'd1,
    MODE_OVER = 2'd2
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] wlog2;
    logic [7:0] h;
    logic       en;
  } sprite_desc_t;

  localparam logic [23:0] KEY_COLOR_DEF = 24'hFF0000;
  localparam logic [23:0] BG_COLOR_DEF  = 24'hB7FE7B;

  // Widest in-sprite offset: 7-bit column + (8-bit row << up to 7).
  localparam int SPR_OFS_W = 15;

  // Darken a colour by shifting every channel right by sh.
  function automatic rgb_t rgb_shr(input rgb_t c, input logic [2:0] sh);
    rgb_t o;
    o.r = c.r >> sh;
    o.g = c.g >> sh;
    o.b = c.b >> sh;
    return o;
  endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// -----------------------------------------------------------------------------
// sprite_hit_unit
// First pipeline stage for one sprite layer: decides whether the current pixel
// falls inside the sprite rectangle and forms the sprite-ROM address.
// Ports:
//   clk_i, rst_ni   pixel clock, asynchronous active-low reset
//   draw_x_i/_y_i   current pixel coordinates
//   desc_i          layer placement descriptor
//   hit_o           registered hit flag
//   addr_o          registered ROM address (0 when no hit)
// -----------------------------------------------------------------------------
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter int ADDR_W = 19
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [9:0]         draw_x_i,
  input  logic [9:0]         draw_y_i,
  input  sprite_desc_t       desc_i,
  output logic               hit_o,
  output logic [ADDR_W-1:0]  addr_o
);

  logic [10:0]          x_end_s;
  logic [10:0]          y_end_s;
  logic [6:0]           dx_s;
  logic [7:0]           dy_s;
  logic [SPR_OFS_W-1:0] ofs_s;
  logic                 hit_d, hit_q;
  logic [ADDR_W-1:0]    addr_d, addr_q;

  // Rectangle test and address; bounds kept in 11 bits so a sprite that
  // runs past X=1023 does not wrap back onto the left edge.
  always_comb begin
    x_end_s = {1'b0, desc_i.x} + (11'd1 << desc_i.wlog2);
    y_end_s = {1'b0, desc_i.y} + {3'b000, desc_i.h};
    hit_d   = desc_i.en
            && ({1'b0, draw_x_i} >= {1'b0, desc_i.x}) && ({1'b0, draw_x_i} < x_end_s)
            && ({1'b0, draw_y_i} >= {1'b0, desc_i.y}) && ({1'b0, draw_y_i} < y_end_s);
    dx_s    = 7'(draw_x_i - desc_i.x);
    dy_s    = 8'(draw_y_i - desc_i.y);
    ofs_s   = {8'd0, dx_s} + ({7'd0, dy_s} << desc_i.wlog2);
    if (hit_d) begin
      addr_d = ADDR_W'(ofs_s);
    end else begin
      addr_d = '0;
    end
  end

  // Stage-0 registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      hit_q  <= hit_d;
      addr_q <= addr_d;
    end
  end

  assign hit_o  = hit_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/sprite_compositor.sv
// -----------------------------------------------------------------------------
// sprite_compositor
// N-layer sprite compositor between game logic and the VGA controller.
// Stage 0: per-layer hit + ROM address (sprite_hit_unit, registered).
// Stage 1: ROM data returns; transparency key, fixed priority (layer 0 on
//          top), background, fade shading; registered RGB. Latency 2.
// Also owns the PLAY/FADE/OVER mode and per-frame collision flags.
// Ports:
//   Clk, Reset_n            pixel clock, asynchronous active-low reset
//   pix_valid, frame_start  active-video qualifier, first-pixel-of-frame pulse
//   DrawX, DrawY            pixel coordinates
//   spr_en/x/y/wlog2/h      packed per-layer placement
//   rom_addr / rom_data     per-layer sprite ROM address out / RGB back
//   game_over, restart      mode request pulses
//   out_valid, VGA_R/G/B    composed pixel
//   coll_mask, mode         collision flags of the last frame, screen mode
// Build option: define SPRITE_COLLISION_EN to build the collision
// accumulator; otherwise coll_mask is tied to 0.
// -----------------------------------------------------------------------------
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int          NUM_SPR     = 8,
  parameter int          ADDR_W      = 19,
  parameter logic [23:0] KEY_COLOR   = KEY_COLOR_DEF,
  parameter logic [23:0] BG_COLOR    = BG_COLOR_DEF,
  parameter int          FADE_FRAMES = 4,
  parameter int          OVL_IDX     = NUM_SPR - 1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      pix_valid,
  input  logic                      frame_start,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic [NUM_SPR-1:0]        spr_en,
  input  logic [NUM_SPR*10-1:0]     spr_x,
  input  logic [NUM_SPR*10-1:0]     spr_y,
  input  logic [NUM_SPR*3-1:0]      spr_wlog2,
  input  logic [NUM_SPR*8-1:0]      spr_h,
  output logic [NUM_SPR*ADDR_W-1:0] rom_addr,
  input  logic [NUM_SPR*24-1:0]     rom_data,
  input  logic                      game_over,
  input  logic                      restart,
  output logic                      out_valid,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic [NUM_SPR-1:0]        coll_mask,
  output logic [1:0]                mode
);

  localparam logic [NUM_SPR-1:0] OVL_MASK  = {{(NUM_SPR-1){1'b0}}, 1'b1} << OVL_IDX;
  localparam logic [2:0]         FADE_LAST = 3'(FADE_FRAMES - 1);

  logic [NUM_SPR-1:0] hit_s;
  logic [NUM_SPR-1:0] opaque_s;
  logic [NUM_SPR-1:0] draw_s;
  rgb_t               pix_s, shade_s;
  rgb_t               rgb_d, rgb_q;
  logic               valid_q, fs_q, out_valid_q;
  mode_e              mode_d, mode_q;
  logic [2:0]         fade_d, fade_q;
  logic               go_pend_d, go_pend_q, rs_pend_d, rs_pend_q;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_layer
    sprite_desc_t desc_s;
    assign desc_s = '{x:     spr_x[i*10 +: 10],
                      y:     spr_y[i*10 +: 10],
                      wlog2: spr_wlog2[i*3 +: 3],
                      h:     spr_h[i*8 +: 8],
                      en:    spr_en[i]};
    sprite_hit_unit #(.ADDR_W(ADDR_W)) u_hit (
      .clk_i    (Clk),
      .rst_ni   (Reset_n),
      .draw_x_i (DrawX),
      .draw_y_i (DrawY),
      .desc_i   (desc_s),
      .hit_o    (hit_s[i]),
      .addr_o   (rom_addr[i*ADDR_W +: ADDR_W])
    );
  end

  // Pixel qualifiers travelling alongside the stage-0 hit registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      valid_q <= pix_valid;
      fs_q    <= frame_start;
    end
  end

  // Stage 1: opacity, priority select (layer 0 last so it wins), shading.
  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) begin
      opaque_s[i] = hit_s[i] & (rom_data[i*24 +: 24] != KEY_COLOR);
    end
    draw_s = (mode_q == MODE_OVER) ? (opaque_s & OVL_MASK) : opaque_s;
    pix_s  = (mode_q == MODE_OVER) ? rgb_t'(24'h000000) : rgb_t'(BG_COLOR);
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      pix_s = draw_s[i] ? rgb_t'(rom_data[i*24 +: 24]) : pix_s;
    end
    if (mode_q == MODE_FADE) begin
      shade_s = rgb_shr(pix_s, fade_q);
    end else begin
      shade_s = pix_s;
    end
    if (valid_q) begin
      rgb_d = shade_s;
    end else begin
      rgb_d = '0;
    end
  end

  // Output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      out_valid_q <= valid_q;
    end
  end

  // Mode next-state: requests are latched and only acted on at frame_start,
  // so the mode (and fade level) never changes inside a frame.
  always_comb begin
    mode_d    = mode_q;
    fade_d    = fade_q;
    go_pend_d = go_pend_q | (game_over & (mode_q == MODE_PLAY));
    rs_pend_d = rs_pend_q | restart;
    if (frame_start) begin
      if (rs_pend_d) begin
        mode_d    = MODE_PLAY;
        fade_d    = 3'd0;
        go_pend_d = 1'b0;
        rs_pend_d = 1'b0;
      end else begin
        case (mode_q)
          MODE_PLAY: begin
            if (go_pend_d) begin
              mode_d    = MODE_FADE;
              fade_d    = 3'd0;
              go_pend_d = 1'b0;
            end else begin
              mode_d = MODE_PLAY;
            end
          end
          MODE_FADE: begin
            if (fade_q == FADE_LAST) begin
              mode_d = MODE_OVER;
              fade_d = 3'd0;
            end else begin
              fade_d = fade_q + 3'd1;
            end
          end
          MODE_OVER: mode_d = MODE_OVER;
          default: begin
            mode_d = MODE_PLAY;
            fade_d = 3'd0;
          end
        endcase
      end
    end else begin
      mode_d = mode_q;
    end
  end

  // Mode state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q    <= MODE_PLAY;
      fade_q    <= 3'd0;
      go_pend_q <= 1'b0;
      rs_pend_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      fade_q    <= fade_d;
      go_pend_q <= go_pend_d;
      rs_pend_q <= rs_pend_d;
    end
  end

`ifdef SPRITE_COLLISION_EN
  localparam logic [NUM_SPR-1:0] ONE = {{(NUM_SPR-1){1'b0}}, 1'b1};

  logic               multi_s;
  logic [NUM_SPR-1:0] contrib_s;
  logic [NUM_SPR-1:0] acc_d, acc_q, coll_d, coll_q;

  // Accumulate opaque overlaps; fs_q marks the stage-1 pixel that opens a
  // new frame, so that pixel seeds the fresh accumulator.
  always_comb begin
    multi_s   = |(opaque_s & (opaque_s - ONE));
    contrib_s = (valid_q && multi_s && (mode_q == MODE_PLAY)) ? opaque_s : '0;
    if (fs_q) begin
      acc_d  = contrib_s;
      coll_d = (mode_q == MODE_PLAY) ? acc_q : '0;
    end else begin
      acc_d  = acc_q | contrib_s;
      coll_d = (mode_q == MODE_PLAY) ? coll_q : '0;
    end
  end

  // Collision registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q  <= '0;
      coll_q <= '0;
    end else begin
      acc_q  <= acc_d;
      coll_q <= coll_d;
    end
  end

  assign coll_mask = coll_q;
`else
  assign coll_mask = '0;
`endif

  assign out_valid = out_valid_q;
  assign VGA_R     = rgb_q.r;
  assign VGA_G     = rgb_q.g;
  assign VGA_B     = rgb_q.b;
  assign mode      = mode_q;

endmodule
